serial_compare_ctrl: RTL and testbench

Sequencing controller that performs a WIDTH-bit magnitude comparison by driving one external 1-bit equality comparator (ports x, y, z; z=1 when x==y) bit-serially, MSB first. It latches two operands on a start handshake and presents one bit pair per cycle. It exits early at the first differing bit and reports eq/gt/lt with a done pulse. It sits between the lab-top operand registers and the shared single-bit comparator instance.

---
 rtl/serial_compare_ctrl_if.sv | 30 +++
 rtl/serial_compare_ctrl.sv | 93 +++++++++
 tb/tb_serial_compare_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/serial_compare_ctrl_if.sv
// Operand/handshake bundle between the operand registers, the sequencer and
// the shared single-bit equality comparator.
interface serial_compare_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cmp_x;
    logic             cmp_y;
    logic             cmp_z;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;

    // Requester side: supplies operands and comparator result, observes status.
    modport master (
        output start, abort, a, b, cmp_z,
        input  cmp_x, cmp_y, busy, done, eq, gt, lt
    );

    // Sequencer side.
    modport slave (
        input  start, abort, a, b, cmp_z,
        output cmp_x, cmp_y, busy, done, eq, gt, lt
    );
endinterface

// File: rtl/serial_compare_ctrl.sv
// Bit-serial WIDTH-bit magnitude compare, MSB first, through an external
// 1-bit equality comparator; exits at the first differing bit.
module serial_compare_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input logic                  clk,
    input logic                  reset,
    serial_compare_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] sra_q;
    logic [WIDTH-1:0] srb_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             eq_q;
    logic             gt_q;
    logic             lt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            sra_q   <= '0;
            srb_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        sra_q   <= bus.a;
                        srb_q   <= bus.b;
                        cnt_q   <= CNT_W'(WIDTH - 1);
                        eq_q    <= 1'b0;
                        gt_q    <= 1'b0;
                        lt_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    // Abort beats a result; the current MSB pair is on cmp_x/cmp_y.
                    if (bus.abort) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (!bus.cmp_z) begin
                        gt_q    <= sra_q[WIDTH-1];
                        lt_q    <= ~sra_q[WIDTH-1];
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (cnt_q == '0) begin
                        eq_q    <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        sra_q <= {sra_q[WIDTH-2:0], 1'b0};
                        srb_q <= {srb_q[WIDTH-2:0], 1'b0};
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Comparator inputs are only live while a compare is in progress.
    assign bus.cmp_x = (state_q == S_COMPARE) ? sra_q[WIDTH-1] : 1'b0;
    assign bus.cmp_y = (state_q == S_COMPARE) ? srb_q[WIDTH-1] : 1'b0;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.eq    = eq_q;
    assign bus.gt    = gt_q;
    assign bus.lt    = lt_q;
endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Bench for serial_compare_ctrl: step-index reference model checked every cycle
// plus directed scenarios with hand-computed latencies and results.
module tb_serial_compare_ctrl;
    localparam int unsigned W = 8;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;
    logic chk_en;

    serial_compare_ctrl_if #(.WIDTH(W)) bus ();

    serial_compare_ctrl #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Ideal 1-bit equality comparator.
    assign bus.cmp_z = (bus.cmp_x == bus.cmp_y);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Position (1 = MSB) of the first differing bit; W when operands are equal.
    function automatic int first_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        for (int i = 1; i <= int'(W); i++)
            if (x[W-i] !== y[W-i]) return i;
        return int'(W);
    endfunction

    // Reference model: m_step is the 1-based cycle within a compare (0 = not comparing).
    int         m_step;
    int         m_k;
    logic       m_done;
    logic [W-1:0] m_a, m_b;
    logic       m_eq, m_gt, m_lt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_step = 0; m_k = 0; m_done = 1'b0;
            m_a = '0; m_b = '0;
            m_eq = 1'b0; m_gt = 1'b0; m_lt = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_step == 0) begin
            if (bus.start && !bus.abort) begin
                m_a = bus.a; m_b = bus.b;
                m_k = first_diff(bus.a, bus.b);
                m_eq = 1'b0; m_gt = 1'b0; m_lt = 1'b0;
                m_step = 1;
            end
        end else if (bus.abort) begin
            m_step = 0;
        end else if (m_step == m_k) begin
            m_eq = (m_a == m_b);
            m_gt = (m_a > m_b);
            m_lt = (m_a < m_b);
            m_step = 0;
            m_done = 1'b1;
        end else begin
            m_step = m_step + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [6:0] exp_v, act_v;
            exp_v = {(m_step > 0) || m_done, m_done, m_eq, m_gt, m_lt,
                     (m_step > 0) ? m_a[W-m_step] : 1'b0,
                     (m_step > 0) ? m_b[W-m_step] : 1'b0};
            act_v = {bus.busy, bus.done, bus.eq, bus.gt, bus.lt, bus.cmp_x, bus.cmp_y};
            check("cycle busy/done/eq/gt/lt/x/y", 32'(act_v), 32'(exp_v));
        end
    end

    // One comparison over a fixed 12-cycle window; measures latency and result.
    task automatic do_cmp(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int abort_at, input logic intr,
                          input int exp_done_cyc, input int exp_busy,
                          input logic [2:0] exp_egl, input logic [1:0] exp_xy1);
        int done_cyc, busy_cnt, done_cnt;
        logic [1:0] xy1;
        done_cyc = 0; busy_cnt = 0; done_cnt = 0; xy1 = 2'b00;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.start = 1'b1; bus.abort = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            bus.start = intr && (cyc <= 2);
            if (intr && cyc <= 2) bus.a = 8'h11;
            bus.abort = (cyc == abort_at);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin done_cnt++; done_cyc = cyc; end
            if (cyc == 1) xy1 = {bus.cmp_x, bus.cmp_y};
        end
        bus.start = 1'b0; bus.abort = 1'b0;
        check({name, " done cycle"}, 32'(done_cyc), 32'(exp_done_cyc));
        check({name, " busy cycles"}, 32'(busy_cnt), 32'(exp_busy));
        check({name, " done pulses"}, 32'(done_cnt), (exp_done_cyc != 0) ? 32'd1 : 32'd0);
        check({name, " eq/gt/lt"}, 32'({bus.eq, bus.gt, bus.lt}), 32'(exp_egl));
        check({name, " first x/y"}, 32'(xy1), 32'(exp_xy1));
    endtask

    initial begin
        n_pass = 0; n_total = 0; chk_en = 1'b0;
        reset = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.a = '0; bus.b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset outputs", 32'({bus.busy, bus.done, bus.eq, bus.gt, bus.lt, bus.cmp_x, bus.cmp_y}), 32'd0);
        chk_en = 1'b1;

        do_cmp("A5vsA5", 8'hA5, 8'hA5, 0, 1'b0, 9, 9, 3'b100, 2'b11);
        do_cmp("80vs7F", 8'h80, 8'h7F, 0, 1'b0, 2, 2, 3'b010, 2'b10);
        do_cmp("3Cvs3D", 8'h3C, 8'h3D, 0, 1'b0, 9, 9, 3'b001, 2'b00);
        do_cmp("00vsFF busy start", 8'h00, 8'hFF, 0, 1'b1, 2, 2, 3'b001, 2'b01);
        do_cmp("F0vsF0 abort", 8'hF0, 8'hF0, 3, 1'b0, 0, 3, 3'b000, 2'b11);

        // start together with abort in IDLE is refused.
        @(negedge clk);
        bus.a = 8'h12; bus.b = 8'h34; bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        check("start+abort refused", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("start+abort still idle", 32'(bus.busy), 32'd0);

        // Asynchronous reset between edges in cycle 4 of a compare.
        bus.a = 8'h55; bus.b = 8'h55; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-reset busy", 32'(bus.busy), 32'd1);
        #2 reset = 1'b1;
        #1 check("async reset outputs", 32'({bus.busy, bus.done, bus.eq, bus.gt, bus.lt, bus.cmp_x, bus.cmp_y}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        do_cmp("01vs02", 8'h01, 8'h02, 0, 1'b0, 8, 8, 3'b001, 2'b00);
        do_cmp("back-to-back FFvsFE", 8'hFF, 8'hFE, 0, 1'b0, 9, 9, 3'b010, 2'b11);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
